// File: rtl/seq_nonrestoring_divider.sv
// Multi-cycle non-restoring integer divider with valid/ready handshakes on both sides.
// Retires BITS_PER_CYCLE quotient bits per clock; signed or unsigned per request, explicit divide-by-zero flag.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | iterating non-restoring steps on the magnitudes
// FIX   | final remainder correction and sign application
// DONE  | result presented, held until out_ready
module seq_nonrestoring_divider #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int SIGNED_EN      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);
    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t state, state_nx;

    logic [WIDTH:0]   p, p_nx, p_fix;
    logic [WIDTH-1:0] a, a_nx, d;
    logic [WIDTH-1:0] dvd_mag, dvs_mag, r_mag, q_res, r_res;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, step_neg;
    logic             accept, signed_op, dvd_neg, dvs_neg;

    assign accept    = in_valid && in_ready;
    assign signed_op = (SIGNED_EN != 0) && signed_mode;
    assign dvd_neg   = signed_op && dividend[WIDTH-1];
    assign dvs_neg   = signed_op && divisor[WIDTH-1];
    assign dvd_mag   = dvd_neg ? -dividend : dividend;
    assign dvs_mag   = dvs_neg ? -divisor : divisor;

    // P is allowed to wrap during the shift; the add/subtract brings it back into [-D, D).
    always_comb begin
        p_nx     = p;
        a_nx     = a;
        step_neg = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            step_neg = p_nx[WIDTH];
            p_nx     = {p_nx[WIDTH-1:0], a_nx[WIDTH-1]};
            p_nx     = step_neg ? (p_nx + {1'b0, d}) : (p_nx - {1'b0, d});
            a_nx     = {a_nx[WIDTH-2:0], ~p_nx[WIDTH]};
        end
    end

    assign p_fix = p[WIDTH] ? (p + {1'b0, d}) : p;
    assign r_mag = p_fix[WIDTH-1:0];
    assign q_res = neg_q ? -a : a;
    assign r_res = neg_r ? -r_mag : r_mag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (accept) state_nx = (divisor == '0) ? DONE : RUN;
            end
            RUN:  if (cnt == '0) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p           <= '0;
            a           <= '0;
            d           <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (divisor == '0) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end else begin
                        a           <= dvd_mag;
                        d           <= dvs_mag;
                        p           <= '0;
                        neg_q       <= dvd_neg ^ dvs_neg;
                        neg_r       <= dvd_neg;
                        cnt         <= CW'(STEPS - 1);
                        div_by_zero <= 1'b0;
                    end
                end
                RUN: begin
                    p   <= p_nx;
                    a   <= a_nx;
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    quotient  <= q_res;
                    remainder <= r_res;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_nonrestoring_divider.sv
// Self-checking bench: two divider instances (1 and 4 bits per cycle), vector table,
// handshake/reset corner sequences and randomized ops against an arithmetic reference model.
module tb_seq_nonrestoring_divider;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  dividend = '0, divisor = '0;
    logic          signed_mode = 1'b0;
    logic          in_valid[2], out_ready[2], in_ready[2], out_valid[2], div_by_zero[2], busy[2];
    logic [W-1:0]  quotient[2], remainder[2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_nonrestoring_divider #(.WIDTH(W), .BITS_PER_CYCLE(1), .SIGNED_EN(1)) u_bpc1 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .dividend(dividend), .divisor(divisor), .signed_mode(signed_mode),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .quotient(quotient[0]),
        .remainder(remainder[0]), .div_by_zero(div_by_zero[0]), .busy(busy[0]));

    seq_nonrestoring_divider #(.WIDTH(W), .BITS_PER_CYCLE(4), .SIGNED_EN(1)) u_bpc4 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .dividend(dividend), .divisor(divisor), .signed_mode(signed_mode),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .quotient(quotient[1]),
        .remainder(remainder[1]), .div_by_zero(div_by_zero[1]), .busy(busy[1]));

    typedef struct {
        int          k;
        logic [31:0] x, y;
        logic        sm;
        logic [31:0] q, r;
        logic        dz;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic sm,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sx, sy;
        dz = (y == 0);
        if (y == 0) begin
            q = '1;
            r = x;
        end else if (sm) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q  = 32'(sx / sy);
            r  = 32'(sx % sy);
        end else begin
            q = x / y;
            r = x % y;
        end
    endfunction

    // Issues one op on instance k and returns the result plus the accept-to-out_valid latency.
    task automatic run_op(input int k, input logic [31:0] x, input logic [31:0] y, input logic sm,
                          input logic pre, output logic [31:0] q, output logic [31:0] r,
                          output logic dz, output int lat);
        int guard;
        @(negedge clk);
        dividend = x; divisor = y; signed_mode = sm;
        in_valid[k] = 1'b1; out_ready[k] = pre;
        guard = 0;
        while (!in_ready[k] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready[k]) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        dividend = $urandom; divisor = $urandom; signed_mode = ~sm;
        lat = 1;
        while (!out_valid[k] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid[k]) check("out_valid_timeout", 0, 1);
        q = quotient[k]; r = remainder[k]; dz = div_by_zero[k];
        out_ready[k] = 1'b1;
        @(negedge clk);
        check("out_valid_drop", out_valid[k], 0);
        out_ready[k] = 1'b0;
    endtask

    vec_t        vecs[$];
    logic [31:0] q, r, eq, er, x, y, hq;
    logic        dz, edz, sm;
    int          lat, seen;

    initial begin
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0;
            out_ready[k] = 1'b0;
        end
        vecs.push_back('{0, 32'd87, 32'd5, 1'b0, 32'd17, 32'd2, 1'b0, 34});
        vecs.push_back('{0, 32'hFFFFFFFF, 32'd2, 1'b0, 32'h7FFFFFFF, 32'd1, 1'b0, 34});
        vecs.push_back('{0, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34});
        vecs.push_back('{0, 32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0, 34});
        vecs.push_back('{0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, 34});
        vecs.push_back('{0, 32'd100, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd100, 1'b1, 1});
        vecs.push_back('{0, 32'd100, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd100, 1'b1, 1});
        vecs.push_back('{0, 32'd87, 32'd5, 1'b0, 32'd17, 32'd2, 1'b0, 34});
        vecs.push_back('{0, 32'd3, 32'd10, 1'b0, 32'd0, 32'd3, 1'b0, 34});
        vecs.push_back('{1, 32'h12345678, 32'd1, 1'b0, 32'h12345678, 32'd0, 1'b0, 10});
        vecs.push_back('{1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'd1, 32'd0, 1'b0, 10});
        vecs.push_back('{1, 32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 10});
        vecs.push_back('{1, 32'h80000000, 32'h80000000, 1'b1, 32'd1, 32'd0, 1'b0, 10});
        vecs.push_back('{1, 32'h80000000, 32'd7, 1'b0, 32'h12492492, 32'd2, 1'b0, 10});

        #3;
        for (int k = 0; k < 2; k++) begin
            check("reset_flags", {in_ready[k], out_valid[k], busy[k], div_by_zero[k]}, 4'b1000);
            check("reset_data", {quotient[k], remainder[k]}, 64'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].k, vecs[i].x, vecs[i].y, vecs[i].sm, 1'b0, q, r, dz, lat);
            check($sformatf("vec%0d_q", i), q, vecs[i].q);
            check($sformatf("vec%0d_r", i), r, vecs[i].r);
            check($sformatf("vec%0d_dz", i), dz, vecs[i].dz);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        end

        // Result held while out_ready is low; inputs wiggle meanwhile.
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd7; signed_mode = 1'b0;
        in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        lat = 1;
        while (!out_valid[0] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("hold_lat", lat, 34);
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = i[0];
            dividend = $urandom;
            check("hold_valid", out_valid[0], 1);
            check("hold_data", {quotient[0], remainder[0]}, {32'd142, 32'd6});
            check("hold_in_ready", in_ready[0], 0);
            @(negedge clk);
        end
        in_valid[0] = 1'b1; dividend = 32'd5; divisor = 32'd1; out_ready[0] = 1'b1;
        @(negedge clk);
        check("no_accept_on_handshake", {out_valid[0], busy[0], in_ready[0]}, 3'b001);
        in_valid[0] = 1'b0; out_ready[0] = 1'b0;

        // out_ready already high: out_valid lasts exactly one cycle.
        @(negedge clk);
        dividend = 32'd50; divisor = 32'd8; signed_mode = 1'b0;
        in_valid[1] = 1'b1; out_ready[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid[1]) begin
                seen++;
                check("pre_ready_data", {quotient[1], remainder[1]}, {32'd6, 32'd2});
            end
            @(negedge clk);
        end
        check("pre_ready_pulse", seen, 1);
        out_ready[1] = 1'b0;

        // Reset asserted mid-RUN discards the operation.
        @(negedge clk);
        dividend = 32'h12345678; divisor = 32'd3; signed_mode = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_run_busy", busy[0], 1);
        #2 reset = 1'b0;
        #1;
        check("mid_reset_flags", {in_ready[0], out_valid[0], busy[0], div_by_zero[0]}, 4'b1000);
        check("mid_reset_data", {quotient[0], remainder[0]}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid[0] || !in_ready[0]) seen++;
        end
        check("post_reset_idle", seen, 0);
        run_op(0, 32'd59, 32'd20, 1'b0, 1'b0, q, r, dz, lat);
        check("post_reset_op", {q, r}, {32'd2, 32'd19});

        // Randomized ops against the reference model.
        for (int n = 0; n < 3200; n++) begin
            int k;
            k  = (n < 3000) ? 1 : 0;
            sm = (n < 1500 || n >= 3100) ? 1'b0 : 1'b1;
            x  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0: y = $urandom;
                1: y = $urandom_range(1, 16);
                2: y = 32'd0;
                3: y = 32'hFFFFFFFF;
                4: y = x;
                default: y = $urandom >> $urandom_range(0, 31);
            endcase
            model(x, y, sm, eq, er, edz);
            run_op(k, x, y, sm, 1'($urandom_range(0, 1)), q, r, dz, lat);
            check($sformatf("rnd%0d_q x=%0h y=%0h s=%0b", n, x, y, sm), q, eq);
            check($sformatf("rnd%0d_r x=%0h y=%0h s=%0b", n, x, y, sm), r, er);
            check($sformatf("rnd%0d_dz", n), dz, edz);
            check($sformatf("rnd%0d_lat", n), lat, edz ? 1 : ((k == 1) ? 10 : 34));
        end

        hq = quotient[1];
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
